// File: rtl/ifetch.sv
// rtl/ifetch.sv - single-outstanding instruction fetch unit
//
// Ports:
//   clk, nrst                       clock, synchronous active-low reset
//   imem_req_valid/ready/addr       instruction-memory read request
//   imem_rsp_valid/data             instruction-memory read response
//   instr_valid, instr_out, pc      fetched instruction held for the control stage
//   pc_next, instr_ack              next PC and retire strobe from the control stage
//   fetch_err                       sticky misaligned-target trap
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic        instr_ack,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Responses are only consumed in WAIT and acks only in HOLD, so a stray
  // rsp_valid or ack in any other state has no effect by construction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          pc_d    = pc_next;
          // A misaligned target is still latched into pc so it can be inspected.
          state_d = (pc_next[1:0] == 2'b00) ? S_REQ : S_TRAP;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr_out      = instr_q;
  assign pc             = pc_q;
  assign fetch_err      = (state_q == S_TRAP);

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard testbench for ifetch
module tb_ifetch;

  logic        clk;
  logic        nrst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        instr_ack;
  logic        fetch_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] req_q[$];
  logic [31:0] ret_pc_q[$];
  logic [31:0] ret_ins_q[$];

  ifetch dut (
    .clk            (clk),
    .nrst           (nrst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc             (pc),
    .pc_next        (pc_next),
    .instr_ack      (instr_ack),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a handshake.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, req_q.pop_front());
        end
      end
      if (instr_valid && instr_ack) begin
        if (ret_pc_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_retire: got pc %h instr %h expected none", pc, instr_out);
        end else begin
          chk("retire_pc", pc, ret_pc_q.pop_front());
          chk("retire_instr", instr_out, ret_ins_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Issue one accepted request from REQ and a response one cycle later.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    chk("fo_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("fo_req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    req_q.push_back(addr);
    tick();
    imem_req_ready = 1'b0;
    chk("fo_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    chk("fo_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("fo_instr_out", instr_out, data);
  endtask

  // Retire the held instruction with the given target.
  task automatic ack(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] tgt);
    instr_ack = 1'b1;
    pc_next   = tgt;
    ret_pc_q.push_back(addr);
    ret_ins_q.push_back(data);
    tick();
    instr_ack = 1'b0;
  endtask

  initial begin
    nrst           = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pc_next        = 32'h0;
    instr_ack      = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // Basic fetch: instr_valid at cycle 3, req addr 4 after ack
    nrst = 1'b1;
    tick();
    fetch_one(32'h0, 32'h0050_0093);
    chk("hold_pc", pc, 32'h0);
    tick();
    chk("hold2_instr_valid", {31'd0, instr_valid}, 32'd1);
    ack(32'h0, 32'h0050_0093, 32'h4);
    chk("ack_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("ack_req_addr", imem_req_addr, 32'h4);
    chk("ack_pc", pc, 32'h4);
    chk("ack_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("ack_instr_kept", instr_out, 32'h0050_0093);

    // Stall in REQ with ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h4);
    end

    // Slow memory: response three cycles after acceptance
    imem_req_ready = 1'b1;
    req_q.push_back(32'h4);
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("slow_req_valid", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0113;
    tick();
    imem_rsp_valid = 1'b0;

    // HOLD ignores stray responses while waiting for ack
    for (int i = 0; i < 10; i++) begin
      imem_rsp_valid = i[0];
      imem_rsp_data  = 32'hDEAD_BEEF;
      chk("hold_stable_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_stable_instr", instr_out, 32'h00A0_0113);
      chk("hold_stable_pc", pc, 32'h4);
      tick();
    end

    // Simultaneous response and ack: ack wins, response dropped
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    ack(32'h4, 32'h00A0_0113, 32'hFFFF_FFFC);
    imem_rsp_valid = 1'b0;
    chk("both_instr", instr_out, 32'h00A0_0113);
    chk("both_req_addr", imem_req_addr, 32'hFFFF_FFFC);

    // Top-of-memory address, then wrap to 0
    fetch_one(32'hFFFF_FFFC, 32'h1234_5678);
    ack(32'hFFFF_FFFC, 32'h1234_5678, 32'h0);
    chk("wrap_req_addr", imem_req_addr, 32'h0);

    // Back-to-back retirement, 3 cycles per instruction
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      fetch_one(a, 32'h0000_0093 | (a << 20));
      ack(a, 32'h0000_0093 | (a << 20), a + 32'h4);
    end
    chk("b2b_req_addr", imem_req_addr, 32'h10);

    // Misaligned target traps
    fetch_one(32'h10, 32'h0000_0073);
    ack(32'h10, 32'h0000_0073, 32'h0000_0102);
    chk("trap_err", {31'd0, fetch_err}, 32'd1);
    chk("trap_pc", pc, 32'h0000_0102);
    chk("trap_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("trap_instr_valid", {31'd0, instr_valid}, 32'd0);
    imem_req_ready = 1'b1;
    instr_ack      = 1'b1;
    imem_rsp_valid = 1'b1;
    pc_next        = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_sticky_err", {31'd0, fetch_err}, 32'd1);
      chk("trap_sticky_pc", pc, 32'h0000_0102);
    end
    imem_req_ready = 1'b0;
    instr_ack      = 1'b0;
    imem_rsp_valid = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("trap_rst_pc", pc, 32'h0);
    chk("trap_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("trap_rst_instr", instr_out, 32'h0000_0013);
    tick();

    // Reset in WAIT with a late response after reset
    imem_req_ready = 1'b1;
    req_q.push_back(32'h0);
    tick();
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    nrst           = 1'b0;
    imem_req_ready = 1'b1;
    instr_ack      = 1'b1;
    tick();
    nrst           = 1'b1;
    imem_req_ready = 1'b0;
    instr_ack      = 1'b0;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    chk("late_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("late_req_addr", imem_req_addr, 32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_instr", instr_out, 32'h0000_0013);
    chk("late_req_valid2", {31'd0, imem_req_valid}, 32'd1);
    fetch_one(32'h0, 32'h0030_0193);
    ack(32'h0, 32'h0030_0193, 32'h4);
    chk("final_req_addr", imem_req_addr, 32'h4);
    tick();

    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("ret_q_drained", 32'(ret_pc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
